// File: rtl/axis_slice_pkg.sv
// Shared types and helpers for the AXI4-Stream register slice.
package axis_slice_pkg;

  // How a slice stage breaks timing paths.
  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  // Largest sensible chain length; longer chains add latency without helping timing.
  localparam int MAX_STAGES = 4;

  // Each stage can hold up to two beats (main + skid), so the count spans 0..2*stages.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  // Maps the integer MODE parameter onto the enum; unknown values fall back to full skid.
  function automatic slice_mode_e to_mode(input int mode);
    case (mode)
      0:       return SLICE_BYPASS;
      1:       return SLICE_FWD;
      default: return SLICE_FULL;
    endcase
  endfunction

endpackage

// File: rtl/axis_slice_stage.sv
// One AXI4-Stream pipeline stage. FWD registers valid/payload only;
// FULL adds a skid register so ready is registered as well.
module axis_slice_stage
  import axis_slice_pkg::*;
#(
  parameter int          PW   = 8,
  parameter slice_mode_e MODE = SLICE_FULL
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vld_up,
  output logic          rdy_up,
  input  logic [PW-1:0] data_up,
  output logic          vld_dn,
  input  logic          rdy_dn,
  output logic [PW-1:0] data_dn,
  output logic [1:0]    occ
);

  generate
    if (MODE == SLICE_FULL) begin : g_full
      logic          main_vld_q, skid_vld_q, rdy_q;
      logic [PW-1:0] main_q, skid_q;
      logic          main_vld_d, skid_vld_d;
      logic [PW-1:0] main_d, skid_d;
      logic          accept, pop;

      // Next-state for main/skid: refill main from skid first, overwrite main
      // on simultaneous accept+pop, and spill to skid only when main is stuck.
      always_comb begin
        accept     = vld_up & rdy_q;
        pop        = main_vld_q & rdy_dn;
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (pop) begin
          if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
          end else if (accept) begin
            main_d = data_up;
          end else begin
            main_vld_d = 1'b0;
          end
        end else if (accept) begin
          if (main_vld_q) begin
            skid_d     = data_up;
            skid_vld_d = 1'b1;
          end else begin
            main_d     = data_up;
            main_vld_d = 1'b1;
          end
        end
      end

      // State registers; ready is held low in reset and rises one edge after release.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          main_vld_q <= 1'b0;
          skid_vld_q <= 1'b0;
          main_q     <= '0;
          skid_q     <= '0;
          rdy_q      <= 1'b0;
        end else begin
          main_vld_q <= main_vld_d;
          skid_vld_q <= skid_vld_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          rdy_q      <= ~skid_vld_d;
        end
      end

      assign rdy_up  = rdy_q;
      assign vld_dn  = main_vld_q;
      assign data_dn = main_q;
      assign occ     = 2'(main_vld_q) + 2'(skid_vld_q);

    end else if (MODE == SLICE_FWD) begin : g_fwd
      logic          vld_q;
      logic [PW-1:0] data_q;

      assign rdy_up = ~vld_q | rdy_dn;

      // Single holding register; loads whenever it is empty or draining this cycle.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q  <= 1'b0;
          data_q <= '0;
        end else if (rdy_up) begin
          vld_q <= vld_up;
          if (vld_up) begin
            data_q <= data_up;
          end
        end
      end

      assign vld_dn  = vld_q;
      assign data_dn = data_q;
      assign occ     = 2'(vld_q);

    end else begin : g_bypass
      assign rdy_up  = rdy_dn;
      assign vld_dn  = vld_up;
      assign data_dn = data_up;
      assign occ     = 2'd0;
    end
  endgenerate

endmodule

// File: rtl/axis_pipe_slice.sv
// AXI4-Stream register slice: STAGES chained stages between slave and master,
// or plain wires in bypass mode. Payload travels as {tlast, tuser, tkeep, tdata}.
// STAGES is intended to stay within 1..MAX_STAGES.
module axis_pipe_slice
  import axis_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int DATA_COUNT = DATA_WIDTH / 8,
  parameter int STAGES     = 1,
  parameter int MODE       = 2,
  parameter int OCC_W      = occ_width(STAGES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [DATA_COUNT-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [DATA_COUNT-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int          PW    = DATA_WIDTH + DATA_COUNT + USER_WIDTH + 1;
  localparam slice_mode_e SMODE = to_mode(MODE);

  generate
    if (SMODE == SLICE_BYPASS) begin : g_bypass
      assign s_axis_tready = m_axis_tready;
      assign m_axis_tvalid = s_axis_tvalid;
      assign m_axis_tdata  = s_axis_tdata;
      assign m_axis_tkeep  = s_axis_tkeep;
      assign m_axis_tuser  = s_axis_tuser;
      assign m_axis_tlast  = s_axis_tlast;
      assign occupancy     = '0;

    end else begin : g_chain
      logic [PW-1:0] pl  [STAGES+1];
      logic          vld [STAGES+1];
      logic          rdy [STAGES+1];
      logic [1:0]    socc[STAGES];
      logic [OCC_W-1:0] occ_sum;

      assign pl[0]         = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
      assign vld[0]        = s_axis_tvalid;
      assign s_axis_tready = rdy[0];

      for (genvar g = 0; g < STAGES; g++) begin : g_stage
        axis_slice_stage #(
          .PW   (PW),
          .MODE (SMODE)
        ) u_stage (
          .clk     (clk),
          .rstn    (rstn),
          .vld_up  (vld[g]),
          .rdy_up  (rdy[g]),
          .data_up (pl[g]),
          .vld_dn  (vld[g+1]),
          .rdy_dn  (rdy[g+1]),
          .data_dn (pl[g+1]),
          .occ     (socc[g])
        );
      end

      assign m_axis_tvalid = vld[STAGES];
      assign rdy[STAGES]   = m_axis_tready;
      assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = pl[STAGES];

      // Total beats held across the chain, for debug and backpressure monitoring.
      always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
          occ_sum = occ_sum + OCC_W'(socc[i]);
        end
      end

      assign occupancy = occ_sum;
    end
  endgenerate

endmodule

// File: tb/tb_axis_pipe_slice.sv
// Testbench for axis_pipe_slice: four instances (FULL x3, FULL x2, FWD x2, BYPASS)
// checked against a FIFO-order reference model of the stream.
module tb_axis_pipe_slice;

  localparam int DW = 32;
  localparam int UW = 2;
  localparam int KW = DW / 8;
  localparam int PW = DW + KW + UW + 1;

  function automatic int dutMode(input int i);
    case (i)
      0:       return 2;
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dutStages(input int i);
    case (i)
      0:       return 3;
      1:       return 2;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic          sTvalid[4];
  logic          sTready[4];
  logic [DW-1:0] sTdata [4];
  logic [KW-1:0] sTkeep [4];
  logic [UW-1:0] sTuser [4];
  logic          sTlast [4];
  logic          mTvalid[4];
  logic          mTready[4];
  logic [DW-1:0] mTdata [4];
  logic [KW-1:0] mTkeep [4];
  logic [UW-1:0] mTuser [4];
  logic          mTlast [4];
  logic [3:0]    occ    [4];

  int vectors = 0;
  int errors  = 0;

  logic [PW-1:0] expq[$];
  logic          stallPending = 1'b0;
  logic [PW-1:0] heldPl;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int ST = dutStages(g);
      localparam int MD = dutMode(g);
      logic [$clog2(2*ST+1)-1:0] occLocal;

      axis_pipe_slice #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .DATA_COUNT (KW),
        .STAGES     (ST),
        .MODE       (MD)
      ) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (sTvalid[g]),
        .s_axis_tready (sTready[g]),
        .s_axis_tdata  (sTdata[g]),
        .s_axis_tkeep  (sTkeep[g]),
        .s_axis_tuser  (sTuser[g]),
        .s_axis_tlast  (sTlast[g]),
        .m_axis_tvalid (mTvalid[g]),
        .m_axis_tready (mTready[g]),
        .m_axis_tdata  (mTdata[g]),
        .m_axis_tkeep  (mTkeep[g]),
        .m_axis_tuser  (mTuser[g]),
        .m_axis_tlast  (mTlast[g]),
        .occupancy     (occLocal)
      );

      assign occ[g] = 4'(occLocal);
    end
  endgenerate

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [PW-1:0] mPayload(input int d);
    return {mTlast[d], mTuser[d], mTkeep[d], mTdata[d]};
  endfunction

  function automatic logic [PW-1:0] sPayload(input int d);
    return {sTlast[d], sTuser[d], sTkeep[d], sTdata[d]};
  endfunction

  function automatic logic [PW-1:0] mkPayload(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                                              input logic [UW-1:0] user, input logic last);
    return {last, user, keep, data};
  endfunction

  function automatic logic [PW-1:0] randPayload();
    return {1'($urandom), UW'($urandom), KW'($urandom), DW'($urandom)};
  endfunction

  // One clock of traffic on DUT d: drive inputs, resolve handshakes before the
  // edge, and keep the reference FIFO in step. Held beats = accepted - delivered.
  task automatic applyStimulus(input int d, input logic sv, input logic [PW-1:0] pl, input logic mr,
                               output logic sf, output logic mf);
    sTvalid[d] = sv;
    {sTlast[d], sTuser[d], sTkeep[d], sTdata[d]} = pl;
    mTready[d] = mr;
    #1;
    sf = sv & sTready[d];
    mf = mTvalid[d] & mr;
    if (stallPending) begin
      checkOutput("stall hold", 64'({mTvalid[d], mPayload(d)}), 64'({1'b1, heldPl}));
    end
    stallPending = mTvalid[d] & ~mr;
    heldPl       = mPayload(d);
    if (mf) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected beat", 64'(1), 64'(0));
      end else begin
        checkOutput("payload", 64'(mPayload(d)), 64'(expq.pop_front()));
      end
    end
    if (sf) begin
      expq.push_back(pl);
    end
    @(posedge clk);
    #1;
    checkOutput("occupancy", 64'(occ[d]), 64'(expq.size()));
  endtask

  task automatic idleAll();
    for (int i = 0; i < 4; i++) begin
      sTvalid[i] = 1'b0;
      mTready[i] = 1'b0;
      {sTlast[i], sTuser[i], sTkeep[i], sTdata[i]} = '0;
    end
    stallPending = 1'b0;
    expq.delete();
  endtask

  initial begin
    logic sf, mf;
    int sent, got, cyc, firstS, firstM, lastM;
    logic pend;
    logic [PW-1:0] pendPl;

    idleAll();

    // T1: reset holds outputs quiet even with traffic offered
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sTvalid[i] = 1'b1;
      mTready[i] = 1'b1;
      {sTlast[i], sTuser[i], sTkeep[i], sTdata[i]} = randPayload();
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("T1 m_tvalid in reset", 64'(mTvalid[i]), 64'(0));
      checkOutput("T1 occupancy in reset", 64'(occ[i]), 64'(0));
      checkOutput("T1 m payload in reset", 64'(mPayload(i)), 64'(0));
    end
    checkOutput("T1 full s_tready in reset 0", 64'(sTready[0]), 64'(0));
    checkOutput("T1 full s_tready in reset 1", 64'(sTready[1]), 64'(0));
    idleAll();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("T1 s_tready before first edge 0", 64'(sTready[0]), 64'(0));
    checkOutput("T1 s_tready before first edge 1", 64'(sTready[1]), 64'(0));
    @(posedge clk);
    #1;
    checkOutput("T1 s_tready after first edge 0", 64'(sTready[0]), 64'(1));
    checkOutput("T1 s_tready after first edge 1", 64'(sTready[1]), 64'(1));

    // T2: back-to-back streaming through three full stages
    idleAll();
    sent = 0; got = 0; cyc = 0; firstS = -1; firstM = -1; lastM = -1;
    while (got < 100 && cyc < 400) begin
      applyStimulus(0, sent < 100, mkPayload(DW'(sent), '1, '0, sent == 99), 1'b1, sf, mf);
      if (sf) begin
        if (firstS < 0) firstS = cyc;
        sent++;
      end
      if (mf) begin
        if (firstM < 0) firstM = cyc;
        lastM = cyc;
        got++;
      end
      cyc++;
    end
    checkOutput("T2 beats received", 64'(got), 64'(100));
    checkOutput("T2 latency", 64'(firstM - firstS), 64'(3));
    checkOutput("T2 no bubbles", 64'(lastM - firstM), 64'(99));

    // T3: backpressure fills two full stages with exactly four beats
    idleAll();
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, 1'b1, mkPayload(DW'(sent), '1, '0, 1'b0), 1'b0, sf, mf);
      if (sf) sent++;
    end
    checkOutput("T3 accepted", 64'(sent), 64'(4));
    checkOutput("T3 occupancy full", 64'(occ[1]), 64'(4));
    checkOutput("T3 s_tready low", 64'(sTready[1]), 64'(0));
    got = 0; cyc = 0;
    while (got < 4 && cyc < 20) begin
      applyStimulus(1, 1'b0, '0, 1'b1, sf, mf);
      if (mf) got++;
      cyc++;
    end
    checkOutput("T3 drained", 64'(got), 64'(4));

    // T4: random valid/ready on full (x3) and forward (x2) chains
    for (int k = 0; k < 2; k++) begin
      int d;
      d = (k == 0) ? 0 : 2;
      idleAll();
      sent = 0; got = 0; cyc = 0; pend = 1'b0; pendPl = '0;
      while (got < 2000 && cyc < 20000) begin
        if (!pend && sent < 2000 && $urandom_range(0, 1) == 1) begin
          pend   = 1'b1;
          pendPl = randPayload();
        end
        applyStimulus(d, pend, pend ? pendPl : randPayload(), 1'($urandom_range(0, 1)), sf, mf);
        if (sf) begin
          pend = 1'b0;
          sent++;
        end
        if (mf) got++;
        cyc++;
      end
      checkOutput(k == 0 ? "T4 full beats" : "T4 fwd beats", 64'(got), 64'(2000));
      checkOutput("T4 model empty", 64'(expq.size()), 64'(0));
    end

    // T5: reset in the middle of a packet, then a clean packet
    idleAll();
    sent = 0; cyc = 0;
    while (sent < 3 && cyc < 20) begin
      applyStimulus(0, 1'b1, mkPayload(DW'(32'hA0 + sent), '1, '0, sent == 7), 1'b1, sf, mf);
      if (sf) sent++;
      cyc++;
    end
    checkOutput("T5 valid before reset", 64'(mTvalid[0]), 64'(1));
    rstn = 1'b0;
    #1;
    checkOutput("T5 m_tvalid async drop", 64'(mTvalid[0]), 64'(0));
    checkOutput("T5 occupancy async clear", 64'(occ[0]), 64'(0));
    idleAll();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 60) begin
      applyStimulus(0, sent < 8, mkPayload(DW'(32'hB0 + sent), '1, 2'd1, sent == 7), 1'b1, sf, mf);
      if (sf) sent++;
      if (mf) got++;
      cyc++;
    end
    checkOutput("T5 packet after reset", 64'(got), 64'(8));

    // T6: bypass is pure wiring in both directions
    idleAll();
    for (int c = 0; c < 40; c++) begin
      sTvalid[3] = 1'($urandom);
      mTready[3] = 1'($urandom);
      {sTlast[3], sTuser[3], sTkeep[3], sTdata[3]} = randPayload();
      #1;
      checkOutput("T6 tvalid", 64'(mTvalid[3]), 64'(sTvalid[3]));
      checkOutput("T6 payload", 64'(mPayload(3)), 64'(sPayload(3)));
      checkOutput("T6 tready", 64'(sTready[3]), 64'(mTready[3]));
      checkOutput("T6 occupancy", 64'(occ[3]), 64'(0));
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
